// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 serial-bus blocks (key reader now,
// display writer later): command byte, FSM states and the key decode.
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam int         CMD_BITS      = 8;
  localparam int         READ_BITS     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_TURN,
    ST_READ,
    ST_HOLD
  } state_e;

  // Collapse the four scan bytes into one bit per key: bits 0 and 4 of
  // each byte carry the keys actually wired on the clock board.
  function automatic logic [7:0] decode_keys8(input logic [31:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i]     = k[8*i];
      r[i + 4] = k[8*i + 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Loadable 16-bit down-counter. tick_o is high on the last cycle of a
// period of (load_val_i + 1) cycles; reload on that cycle to chain periods.
module tm1638_bit_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'd0);

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends read-keys command 0x42 LSB-first, turns
// the DIO bus around, clocks in four scan bytes and presents them as one
// 32-bit word with a single-cycle done strobe.
// Optional macro TM1638_KEYDECODE_EN adds the registered keys8 output.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int WAIT_CYC = 64
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] keys,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic        tm_dio_in
`ifdef TM1638_KEYDECODE_EN
  ,
  output logic [7:0]  keys8
`endif
);

  localparam logic [15:0] HALF_LD = 16'(CLK_DIV - 1);
  localparam logic [15:0] TURN_LD = 16'(WAIT_CYC - 1);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;   // 0 = tm_clk low half, 1 = high half
  logic [4:0]  bit_q, bit_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] keys_q, keys_d;
  logic        done_q, done_d;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tick;

  tm1638_bit_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_o     (tick)
  );

  // Bus pins decode straight from registered state so the async reset
  // releases STB immediately and the device aborts the frame.
  always_comb begin
    tm_stb     = (state_q == ST_IDLE);
    tm_clk     = 1'b1;
    tm_dio_oe  = 1'b0;
    tm_dio_out = 1'b0;
    case (state_q)
      ST_SETUP: begin
        tm_dio_oe  = 1'b1;
        tm_dio_out = CMD_READ_KEYS[0];
      end
      ST_CMD: begin
        tm_clk     = phase_q;
        tm_dio_oe  = 1'b1;
        tm_dio_out = CMD_READ_KEYS[bit_q[2:0]];
      end
      ST_READ: tm_clk = phase_q;
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign keys = keys_q;

  // Sequencer: every phase ends on a timer tick, which also reloads the
  // timer for the next phase. Bit index advances at the end of a high
  // half so DIO changes at the start of each low half.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    keys_d   = keys_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HALF_LD;
    case (state_q)
      ST_IDLE: begin
        // done_q marks the return cycle; a start there is dropped.
        if (start && !done_q) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d  = ST_CMD;
          phase_d  = 1'b0;
          bit_d    = 5'd0;
          tmr_load = 1'b1;
        end
      end
      ST_CMD: begin
        if (tick) begin
          tmr_load = 1'b1;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 5'(CMD_BITS - 1)) begin
              state_d = ST_TURN;
              tmr_val = TURN_LD;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      ST_TURN: begin
        if (tick) begin
          state_d  = ST_READ;
          phase_d  = 1'b0;
          bit_d    = 5'd0;
          tmr_load = 1'b1;
        end
      end
      ST_READ: begin
        if (tick) begin
          tmr_load = 1'b1;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Last cycle of the high half: DIO has settled since the fall.
            phase_d = 1'b0;
            shreg_d = {tm_dio_in, shreg_q[31:1]};
            if (bit_q == 5'(READ_BITS - 1)) state_d = ST_HOLD;
            else                            bit_d   = bit_q + 5'd1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          keys_d  = shreg_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      bit_q   <= 5'd0;
      shreg_q <= '0;
      keys_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      keys_q  <= keys_d;
      done_q  <= done_d;
    end
  end

`ifdef TM1638_KEYDECODE_EN
  logic [7:0] keys8_q;

  // Decoded key byte, updated together with keys.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)        keys8_q <= '0;
    else if (done_d) keys8_q <= decode_keys8(keys_d);
  end

  assign keys8 = keys8_q;
`endif

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Scoreboard bench for tm1638_key_reader: stimulus pushes the expected
// word, a monitor checks every done against the queue head.
module tb_tm1638_key_reader;

  localparam int CLK_DIV  = 25;
  localparam int WAIT_CYC = 64;
  localparam int LAT      = 2115;

  logic        clk, RST, start;
  logic        busy, done, tm_stb, tm_clk, tm_dio_out, tm_dio_oe, tm_dio_in;
  logic [31:0] keys;
`ifdef TM1638_KEYDECODE_EN
  logic [7:0]  keys8;
`endif

  tm1638_key_reader #(.CLK_DIV(CLK_DIV), .WAIT_CYC(WAIT_CYC)) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .keys       (keys),
    .tm_stb     (tm_stb),
    .tm_clk     (tm_clk),
    .tm_dio_out (tm_dio_out),
    .tm_dio_oe  (tm_dio_oe),
    .tm_dio_in  (tm_dio_in)
`ifdef TM1638_KEYDECODE_EN
    ,
    .keys8      (keys8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] keys;
    int          t_start;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  logic [31:0] dev_data = '0;
  logic [7:0]  cmd_cap = '0;
  int          rise_cnt = 0, rd_idx = 0, oe_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Device model: records the command at tm_clk rises, presents read
  // bits after each tm_clk fall once the command is complete.
  initial begin : device
    logic clk_p, stb_p;
    clk_p = 1'b1;
    stb_p = 1'b1;
    tm_dio_in = 1'b0;
    forever begin
      @(negedge clk);
      if (stb_p && !tm_stb) begin
        rise_cnt = 0; rd_idx = 0; cmd_cap = '0; oe_err = 0;
      end else if (!tm_stb) begin
        if (!clk_p && tm_clk) begin
          if (rise_cnt < 8) begin
            cmd_cap[rise_cnt] = tm_dio_out;
            if (!tm_dio_oe) oe_err++;
          end else if (tm_dio_oe) begin
            oe_err++;
          end
          rise_cnt++;
        end
        if (clk_p && !tm_clk && rise_cnt >= 8 && rd_idx < 32) begin
          tm_dio_in = dev_data[rd_idx];
          rd_idx++;
        end
      end
      clk_p = tm_clk;
      stb_p = tm_stb;
    end
  end

  // Monitor: every done must match the oldest outstanding request.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done) begin
      done_cnt++;
      chk("done_expected", q.size(), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("keys", keys, e.keys);
        chk("latency", cyc - e.t_start, LAT);
        chk("cmd_bits", cmd_cap, 8'h42);
        chk("oe_turnaround", oe_err, 0);
        chk("busy_on_done", busy, 0);
        chk("stb_on_done", tm_stb, 1);
      end
    end
  end

  task automatic issue(input logic [31:0] data);
    exp_t e;
    @(posedge clk); #1;
    dev_data  = data;
    start     = 1'b1;
    e.keys    = data;
    e.t_start = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("stb_after_start", tm_stb, 0);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q.size(), 0);
  endtask

  task automatic wait_rd(input int idx, input string nm);
    int n = 0;
    while (rd_idx < idx && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, rd_idx >= idx, 1);
  endtask

  initial begin
    int n, dc;
    RST   = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("in_reset", {tm_stb, tm_clk, tm_dio_oe, tm_dio_out, busy, done, keys},
           {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    RST = 1'b1;

    // Idle after reset with no start.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", {tm_stb, tm_clk, tm_dio_oe, busy, done, keys},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    end

    // Single read: bytes 01,10,00,A5.
    issue(32'hA500_1001);
    wait_drain("read1_timeout");

    // Start on the done cycle is dropped.
    issue(32'h5A3C_C33C);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_cycle_start_busy", busy, 0);
    chk("done_cycle_start_stb", tm_stb, 1);
    repeat (5) @(negedge clk);
    chk("done_cycle_start_idle", busy, 0);

    // Start while busy is ignored and not queued.
    dc = done_cnt;
    issue(32'h1234_80FF);
    wait_rd(5, "reach_read");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain("busy_read_timeout");
    repeat (2300) @(negedge clk);
    chk("single_done", done_cnt - dc, 1);
    chk("keys_held", keys, 32'h1234_80FF);
    chk("idle_after_busy_start", busy, 0);

    // Reset during READ bit 12.
    issue(32'hDEAD_BEEF);
    wait_rd(13, "reach_bit12");
    @(posedge clk); #2;
    RST = 1'b0;
    #1 chk("async_reset", {tm_stb, tm_clk, tm_dio_oe, tm_dio_out, busy, done, keys},
           {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    q.delete();
    repeat (3) @(negedge clk);
    RST = 1'b1;
    issue(32'h0F0F_A55A);
    wait_drain("after_reset_timeout");

`ifdef TM1638_KEYDECODE_EN
    // Bytes 11,00,01,10: keys bits 0,4,16,28 set.
    issue(32'h1001_0011);
    wait_drain("decode_timeout");
    chk("keys8", keys8, 8'b1001_0101);
`endif

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
